// File: rtl/bpu_dyn_if.sv
// Fetch-side and execute-side signals of the dynamic branch predictor.
// The predictor takes the slave modport; the pipeline drives the master side.
interface bpu_dyn_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
);
    logic [ADDR_W-1:0] pc_i;
    logic [31:0]       ins_i;
    logic              instr_rsp_vld;
    logic              prdt_taken_o;
    logic [ADDR_W-1:0] jump_op1_o;
    logic [ADDR_W-1:0] jump_op2_o;
    logic [IDX_W-1:0]  prdt_idx_o;
    logic              upd_vld_i;
    logic [IDX_W-1:0]  upd_idx_i;
    logic              upd_taken_i;

    modport master (
        output pc_i, ins_i, instr_rsp_vld,
        output upd_vld_i, upd_idx_i, upd_taken_i,
        input  prdt_taken_o, jump_op1_o, jump_op2_o, prdt_idx_o
    );

    modport slave (
        input  pc_i, ins_i, instr_rsp_vld,
        input  upd_vld_i, upd_idx_i, upd_taken_i,
        output prdt_taken_o, jump_op1_o, jump_op2_o, prdt_idx_o
    );
endinterface

// File: rtl/bpu_dyn.sv
// Dynamic branch predictor: 2-bit counter table indexed by PC.
// Define BPU_RAS_EN to add a circular return-address stack.
module bpu_dyn #(
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    bpu_dyn_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic [31:0]       ins;
    logic [ADDR_W-1:0] pc;
    logic              vld;
    logic              is_jal;
    logic              is_br;
    logic [ADDR_W-1:0] imm_j;
    logic [ADDR_W-1:0] imm_b;
    logic [IDX_W-1:0]  idx;

    assign ins    = bus.ins_i;
    assign pc     = bus.pc_i;
    assign vld    = bus.instr_rsp_vld;
    assign is_jal = ins[6:0] == OP_JAL;
    assign is_br  = ins[6:0] == OP_BR;
    assign idx    = pc[IDX_W+1:2];

    assign imm_j = {{(ADDR_W-21){ins[31]}}, ins[31], ins[19:12],
                    ins[20], ins[30:21], 1'b0};
    assign imm_b = {{(ADDR_W-13){ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};

    logic [BHT_DEPTH-1:0] bht_v;
    logic [1:0]           bht_c [BHT_DEPTH];
    logic                 cur_v;
    logic [1:0]           cur_c;
    logic [1:0]           nxt_c;

    always_comb begin
        cur_v = bht_v[bus.upd_idx_i];
        cur_c = bht_c[bus.upd_idx_i];
        nxt_c = cur_c;
        if (!cur_v)
            nxt_c = bus.upd_taken_i ? 2'b10 : 2'b01;
        else if (bus.upd_taken_i)
            nxt_c = (cur_c == 2'b11) ? 2'b11 : cur_c + 2'b01;
        else
            nxt_c = (cur_c == 2'b00) ? 2'b00 : cur_c - 2'b01;
    end

    // Writes land at the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            bht_v <= '0;
            for (int i = 0; i < BHT_DEPTH; i++)
                bht_c[i] <= 2'b01;
        end else if (bus.upd_vld_i) begin
            bht_v[bus.upd_idx_i] <= 1'b1;
            bht_c[bus.upd_idx_i] <= nxt_c;
        end
    end

`ifdef BPU_RAS_EN
    localparam int RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [RAS_W-1:0]  ras_ptr;
    logic [RAS_W:0]    ras_cnt;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic              is_jalr;
    logic              rd_link;
    logic              rs1_link;
    logic              do_push;
    logic              do_pop;
    logic              pop_hit;
    logic [ADDR_W-1:0] pc4;

    assign rd       = ins[11:7];
    assign rs1      = ins[19:15];
    assign is_jalr  = ins[6:0] == 7'b1100111;
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign pc4      = pc + ADDR_W'(4);
    assign do_push  = vld && (is_jal || is_jalr) && rd_link;
    assign do_pop   = vld && is_jalr && rs1_link &&
                      ((rd == 5'd0) || (rd_link && (rd != rs1)));
    assign pop_hit  = do_pop && (ras_cnt != '0);

    // ras_ptr names the top entry; a push on full wraps onto the oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (pop_hit && do_push) begin
            ras[ras_ptr] <= pc4;
        end else if (do_push) begin
            ras[ras_ptr + 1'b1] <= pc4;
            ras_ptr <= ras_ptr + 1'b1;
            if (ras_cnt != (RAS_W+1)'(RAS_DEPTH))
                ras_cnt <= ras_cnt + 1'b1;
        end else if (pop_hit) begin
            ras_ptr <= ras_ptr - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end
`endif

    logic              taken;
    logic [ADDR_W-1:0] op1;
    logic [ADDR_W-1:0] op2;

    always_comb begin
        taken = 1'b0;
        op1   = pc;
        op2   = ADDR_W'(4);
        unique case (1'b1)
            is_jal: begin
                taken = 1'b1;
                op2   = imm_j;
            end
            is_br: begin
                taken = bht_v[idx] ? bht_c[idx][1] : imm_b[ADDR_W-1];
                op2   = imm_b;
            end
            default: begin
            end
        endcase
`ifdef BPU_RAS_EN
        if (pop_hit) begin
            taken = 1'b1;
            op1   = ras[ras_ptr];
            op2   = '0;
        end
`endif
    end

    logic              hold_taken;
    logic [ADDR_W-1:0] hold_op1;
    logic [ADDR_W-1:0] hold_op2;
    logic [IDX_W-1:0]  hold_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_taken <= 1'b0;
            hold_op1   <= '0;
            hold_op2   <= '0;
            hold_idx   <= '0;
        end else if (vld) begin
            hold_taken <= taken;
            hold_op1   <= op1;
            hold_op2   <= op2;
            hold_idx   <= idx;
        end
    end

    assign bus.prdt_taken_o = vld ? taken : hold_taken;
    assign bus.jump_op1_o   = vld ? op1   : hold_op1;
    assign bus.jump_op2_o   = vld ? op2   : hold_op2;
    assign bus.prdt_idx_o   = vld ? idx   : hold_idx;
endmodule
